// File: rtl/cache_miss_ctrl.sv
// Miss-handling sequencer for a set-associative data cache: picks a victim way,
// writes it back if dirty, refills it word by word from memory, then commits the tag.
module cache_miss_ctrl #(
   parameter  int ADDR_SIZE  = 32,
   parameter  int NUM_SETS   = 16,
   parameter  int NUM_WAYS   = 4,
   parameter  int BLOCK_SIZE = 32,
   localparam int SET_W      = $clog2(NUM_SETS),
   localparam int WAY_W      = $clog2(NUM_WAYS),
   localparam int WORD_W     = $clog2(BLOCK_SIZE),
   localparam int TAG_W      = ADDR_SIZE - SET_W - WORD_W - 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  miss_valid,
   output logic                  miss_ready,
   input  logic [ADDR_SIZE-1:0]  miss_addr,
   input  logic [NUM_WAYS-1:0]   set_valid,
   input  logic [NUM_WAYS-1:0]   set_dirty,
   input  logic [TAG_W-1:0]      victim_tag,
   output logic [SET_W-1:0]      arr_set,
   output logic [WAY_W-1:0]      arr_way,
   output logic [WORD_W-1:0]     arr_word,
   output logic                  arr_rd,
   output logic                  arr_wr,
   output logic                  tag_wr,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_SIZE-1:0]  mem_addr,
   input  logic                  mem_ack,
   output logic                  done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_WB,
      S_REFILL,
      S_COMMIT,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [SET_W-1:0]   set_q, set_d;
   logic [WAY_W-1:0]   way_q, way_d;
   logic [WORD_W-1:0]  cnt_q, cnt_d;
   logic [WAY_W-1:0]   rr_ptr [NUM_SETS];
   logic               rr_adv;

   logic [WAY_W-1:0]   sel_way;
   logic               sel_free;
   logic               last_word;

   // Byte offset and word index of the missing address play no part in the refill.
   logic unused_addr_bits;
   assign unused_addr_bits = ^miss_addr[WORD_W+1:0];

   assign last_word = (cnt_q == WORD_W'(BLOCK_SIZE - 1));

   // Descending scan so the lowest-index invalid way wins.
   always_comb begin
      sel_way  = rr_ptr[set_q];
      sel_free = 1'b0;
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (!set_valid[i]) begin
            sel_way  = WAY_W'(i);
            sel_free = 1'b1;
         end
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      tag_d      = tag_q;
      set_d      = set_q;
      way_d      = way_q;
      cnt_d      = cnt_q;
      rr_adv     = 1'b0;
      miss_ready = 1'b0;
      arr_set    = '0;
      arr_way    = '0;
      arr_word   = '0;
      arr_rd     = 1'b0;
      arr_wr     = 1'b0;
      tag_wr     = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      done       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            miss_ready = 1'b1;
            if (miss_valid) begin
               tag_d   = miss_addr[ADDR_SIZE-1 -: TAG_W];
               set_d   = miss_addr[WORD_W+2 +: SET_W];
               state_d = S_SELECT;
            end
         end

         S_SELECT: begin
            arr_set = set_q;
            way_d   = sel_way;
            rr_adv  = !sel_free;
            cnt_d   = '0;
            if (set_valid[sel_way] && set_dirty[sel_way]) state_d = S_WB;
            else                                          state_d = S_REFILL;
         end

         S_WB: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            arr_rd   = 1'b1;
            arr_set  = set_q;
            arr_way  = way_q;
            arr_word = cnt_q;
            mem_addr = {victim_tag, set_q, cnt_q, 2'b00};
            if (mem_ack) begin
               cnt_d = cnt_q + WORD_W'(1);
               if (last_word) begin
                  cnt_d   = '0;
                  state_d = S_REFILL;
               end
            end
         end

         S_REFILL: begin
            mem_req  = 1'b1;
            arr_set  = set_q;
            arr_way  = way_q;
            arr_word = cnt_q;
            mem_addr = {tag_q, set_q, cnt_q, 2'b00};
            if (mem_ack) begin
               arr_wr = 1'b1;
               cnt_d  = cnt_q + WORD_W'(1);
               if (last_word) begin
                  cnt_d   = '0;
                  state_d = S_COMMIT;
               end
            end
         end

         S_COMMIT: begin
            tag_wr  = 1'b1;
            arr_set = set_q;
            arr_way = way_q;
            state_d = S_DONE;
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   // NOTE: the round-robin pointers are reset explicitly; victim choice after reset must be deterministic.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         tag_q   <= '0;
         set_q   <= '0;
         way_q   <= '0;
         cnt_q   <= '0;
         for (int s = 0; s < NUM_SETS; s++) rr_ptr[s] <= '0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         set_q   <= set_d;
         way_q   <= way_d;
         cnt_q   <= cnt_d;
         if (rr_adv) rr_ptr[set_q] <= rr_ptr[set_q] + WAY_W'(1);
      end
   end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: a block-level cache model predicts memory
// transfers, array strobes, tag commits and done timing; a monitor compares them.
module tb_cache_miss_ctrl;

   localparam int ADDR_SIZE  = 32;
   localparam int NUM_SETS   = 16;
   localparam int NUM_WAYS   = 4;
   localparam int BLOCK_SIZE = 32;
   localparam int SET_W      = 4;
   localparam int WAY_W      = 2;
   localparam int WORD_W     = 5;
   localparam int TAG_W      = ADDR_SIZE - SET_W - WORD_W - 2;

   logic                  clk;
   logic                  rst;
   logic                  miss_valid;
   logic                  miss_ready;
   logic [ADDR_SIZE-1:0]  miss_addr;
   logic [NUM_WAYS-1:0]   set_valid;
   logic [NUM_WAYS-1:0]   set_dirty;
   logic [TAG_W-1:0]      victim_tag;
   logic [SET_W-1:0]      arr_set;
   logic [WAY_W-1:0]      arr_way;
   logic [WORD_W-1:0]     arr_word;
   logic                  arr_rd;
   logic                  arr_wr;
   logic                  tag_wr;
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_SIZE-1:0]  mem_addr;
   logic                  mem_ack;
   logic                  done;

   logic [TAG_W-1:0]      way_tag [NUM_WAYS];
   assign victim_tag = way_tag[arr_way];

   cache_miss_ctrl #(
      .ADDR_SIZE (ADDR_SIZE),
      .NUM_SETS  (NUM_SETS),
      .NUM_WAYS  (NUM_WAYS),
      .BLOCK_SIZE(BLOCK_SIZE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .miss_valid(miss_valid),
      .miss_ready(miss_ready),
      .miss_addr (miss_addr),
      .set_valid (set_valid),
      .set_dirty (set_dirty),
      .victim_tag(victim_tag),
      .arr_set   (arr_set),
      .arr_way   (arr_way),
      .arr_word  (arr_word),
      .arr_rd    (arr_rd),
      .arr_wr    (arr_wr),
      .tag_wr    (tag_wr),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .done      (done)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  set;
      logic [1:0]  way;
      logic [4:0]  word;
   } mem_ev_t;

   mem_ev_t exp_mem [$];
   int      exp_tag_set [$];
   int      exp_tag_way [$];
   int      exp_done [$];
   int      rr_model [NUM_SETS];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int stall    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] blk_addr(input longint tag, input longint set, input longint word);
      return 32'(tag * 2048 + set * 128 + word * 4);
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory responder: acks after `stall` waiting cycles, random acks when idle.
   initial begin
      int          wait_cnt;
      logic [31:0] held_addr;
      logic        held_we;
      wait_cnt = 0;
      mem_ack  = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_req && rst) begin
            if (wait_cnt > 0) begin
               check("stall_addr_stable", mem_addr, held_addr);
               check("stall_we_stable", mem_we, held_we);
            end else begin
               held_addr = mem_addr;
               held_we   = mem_we;
            end
            if (wait_cnt == stall) begin
               mem_ack  = 1'b1;
               wait_cnt = 0;
            end else begin
               mem_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            mem_ack  = 1'($urandom_range(0, 1));
            wait_cnt = 0;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT shows a transfer, commit or done.
   initial forever begin
      mem_ev_t e;
      int      ex_cyc;
      @(negedge clk);
      #1;
      if (rst) begin
         if (mem_req && mem_ack) begin
            if (exp_mem.size() == 0) begin
               check("mem_unexpected", 1, 0);
            end else begin
               e = exp_mem.pop_front();
               check("mem_we", mem_we, e.we);
               check("mem_addr", mem_addr, e.addr);
               check("arr_set", arr_set, e.set);
               check("arr_way", arr_way, e.way);
               check("arr_word", arr_word, e.word);
               if (e.we) check("arr_rd", arr_rd, 1);
               else      check("arr_wr", arr_wr, 1);
            end
         end
         if (arr_wr && !(mem_req && mem_ack && !mem_we)) check("arr_wr_spurious", 1, 0);
         if (tag_wr) begin
            if (exp_tag_set.size() == 0) begin
               check("tag_wr_unexpected", 1, 0);
            end else begin
               check("words_before_commit", exp_mem.size(), 0);
               check("tag_set", arr_set, exp_tag_set.pop_front());
               check("tag_way", arr_way, exp_tag_way.pop_front());
            end
         end
         if (done) begin
            if (exp_done.size() == 0) begin
               check("done_unexpected", 1, 0);
            end else begin
               ex_cyc = exp_done.pop_front();
               check("done_cycle", cyc, ex_cyc);
            end
         end
      end
   end

   task automatic clear_expect();
      exp_mem.delete();
      exp_tag_set.delete();
      exp_tag_way.delete();
      exp_done.delete();
   endtask

   // Predict the whole miss at block level, then present it to the DUT.
   task automatic issue_miss(input logic [31:0] addr, input logic [3:0] valid,
                             input logic [3:0] dirty, input int stall_cyc);
      longint set, tag;
      int     victim, lat;
      bit     wb;
      set    = (longint'(addr) / 128) % 16;
      tag    = longint'(addr) / 2048;
      victim = -1;
      for (int w = 0; w < NUM_WAYS; w++)
         if (victim < 0 && !valid[w]) victim = w;
      if (victim < 0) begin
         victim        = rr_model[set];
         rr_model[set] = (rr_model[set] + 1) % NUM_WAYS;
      end
      wb = valid[victim] && dirty[victim];
      if (wb)
         for (int i = 0; i < BLOCK_SIZE; i++)
            exp_mem.push_back({1'b1, blk_addr(longint'(way_tag[victim]), set, i),
                               4'(set), 2'(victim), 5'(i)});
      for (int i = 0; i < BLOCK_SIZE; i++)
         exp_mem.push_back({1'b0, blk_addr(tag, set, i), 4'(set), 2'(victim), 5'(i)});
      exp_tag_set.push_back(int'(set));
      exp_tag_way.push_back(victim);
      lat = 1 + (wb ? 2 : 1) * BLOCK_SIZE * (stall_cyc + 1) + 2;

      @(negedge clk);
      stall     = stall_cyc;
      set_valid = valid;
      set_dirty = dirty;
      check("miss_ready_idle", miss_ready, 1);
      exp_done.push_back(cyc + lat);
      miss_valid = 1'b1;
      miss_addr  = addr;
      @(negedge clk);
      miss_valid = 1'b0;
      check("miss_ready_busy", miss_ready, 0);
      @(negedge clk);
      miss_valid = 1'b1;
      miss_addr  = $urandom;
      @(negedge clk);
      miss_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (exp_done.size() != 0 && n < 2000) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (exp_done.size() != 0) begin
         check("miss_timeout", 1, 0);
         clear_expect();
      end
   endtask

   task automatic do_miss(input logic [31:0] addr, input logic [3:0] valid,
                          input logic [3:0] dirty, input int stall_cyc);
      issue_miss(addr, valid, dirty, stall_cyc);
      wait_done();
   endtask

   task automatic rand_tags();
      for (int w = 0; w < NUM_WAYS; w++) way_tag[w] = TAG_W'($urandom);
   endtask

   initial begin
      int n, seen;
      rst        = 1'b0;
      miss_valid = 1'b0;
      miss_addr  = '0;
      set_valid  = '0;
      set_dirty  = '0;
      for (int w = 0; w < NUM_WAYS; w++) way_tag[w] = '0;
      for (int s = 0; s < NUM_SETS; s++) rr_model[s] = 0;

      #1;
      check("rst_miss_ready", miss_ready, 1);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_idx", {arr_set, arr_way, arr_word}, 0);
      check("rst_strobes", {arr_rd, arr_wr, tag_wr, mem_we, done}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Idle with random ack noise: nothing may happen.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #2;
         check("idle_ready", miss_ready, 1);
         check("idle_quiet", {mem_req, arr_wr, tag_wr, done}, 0);
      end

      // Clean miss into an invalid way 3.
      rand_tags();
      do_miss(32'h0000_1240, 4'b0111, 4'b0000, 0);

      // Set 5 full: victims 0, 1, then dirty 2 (tag 5), then 3, then wrap to 0.
      rand_tags();
      way_tag[2] = TAG_W'(5);
      do_miss(blk_addr(3, 5, 7),  4'b1111, 4'b0000, 0);
      do_miss(blk_addr(3, 5, 0),  4'b1111, 4'b0000, 0);
      do_miss(blk_addr(3, 5, 31), 4'b1111, 4'b0100, 0);
      do_miss(blk_addr(9, 5, 1),  4'b1111, 4'b0000, 0);
      do_miss(blk_addr(9, 5, 2),  4'b1111, 4'b0000, 0);

      // Reset during refill word 10 of a miss to set 5 (rr there is 1, goes to 2).
      issue_miss(blk_addr(4, 5, 0), 4'b1111, 4'b0000, 0);
      n = 0;
      do begin
         @(negedge clk);
         #2;
         n++;
      end while (!(mem_req && !mem_we && mem_addr[6:2] == 5'd10) && n < 200);
      check("abort_reached_word10", (n < 200), 1);
      rst = 1'b0;
      clear_expect();
      for (int s = 0; s < NUM_SETS; s++) rr_model[s] = 0;
      #1;
      check("abort_rst_ready", miss_ready, 1);
      check("abort_rst_quiet", {mem_req, arr_wr, tag_wr, done}, 0);
      repeat (2) @(negedge clk);
      rst  = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #2;
         if (tag_wr || done) seen++;
      end
      check("abort_no_commit", seen, 0);
      do_miss(blk_addr(4, 5, 3), 4'b1111, 4'b0000, 0);

      // Slow memory with a dirty victim.
      rand_tags();
      do_miss($urandom, 4'b1111, 4'b1111, 5);

      for (int k = 0; k < 25; k++) begin
         rand_tags();
         do_miss($urandom, 4'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
      end

      repeat (5) @(negedge clk);
      check("queues_drained", exp_mem.size() + exp_tag_set.size() + exp_done.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
